// File: rtl/attn_score_engine.sv
// Attention score engine: S = Q*K^T for one head, streamed through the result SRAM ports.
// Latency: 2*dim+2 cycles per S element, seq_len^2 elements; degenerate operands finish in 2 cycles.
// Backpressure: none; start_valid is only honoured while ready is high, and is ignored while busy.
module attn_score_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_valid,
    output logic                  ready,
    input  logic [DIM_WIDTH-1:0]  seq_len,
    input  logic [DIM_WIDTH-1:0]  dim,
    input  logic [ADDR_WIDTH-1:0] q_base,
    input  logic [ADDR_WIDTH-1:0] k_base,
    input  logic [ADDR_WIDTH-1:0] s_base,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  sram_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_write_address,
    output logic [DATA_WIDTH-1:0] sram_write_data
);

    typedef enum logic [2:0] {IDLE, RD_Q, RD_K, DRAIN, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic [DIM_WIDTH-1:0]  seq_r, seq_nxt;
    logic [DIM_WIDTH-1:0]  dim_r, dim_nxt;
    logic [DIM_WIDTH-1:0]  i_idx, i_nxt;
    logic [DIM_WIDTH-1:0]  j_idx, j_nxt;
    logic [DIM_WIDTH-1:0]  k_idx, k_nxt;
    logic [ADDR_WIDTH-1:0] kb_r, kb_nxt;
    logic [ADDR_WIDTH-1:0] q_row, q_row_nxt;
    logic [ADDR_WIDTH-1:0] k_row, k_row_nxt;
    logic [ADDR_WIDTH-1:0] s_addr, s_addr_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [DATA_WIDTH-1:0] q_reg, q_reg_nxt;
    logic [DATA_WIDTH-1:0] prod;

    // Low DATA_WIDTH bits are identical for signed and unsigned operands.
    assign prod = q_reg * sram_read_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            seq_r   <= '0;
            dim_r   <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            k_idx   <= '0;
            kb_r    <= '0;
            q_row   <= '0;
            k_row   <= '0;
            s_addr  <= '0;
            rd_addr <= '0;
            acc     <= '0;
            q_reg   <= '0;
        end else begin
            state   <= state_nxt;
            seq_r   <= seq_nxt;
            dim_r   <= dim_nxt;
            i_idx   <= i_nxt;
            j_idx   <= j_nxt;
            k_idx   <= k_nxt;
            kb_r    <= kb_nxt;
            q_row   <= q_row_nxt;
            k_row   <= k_row_nxt;
            s_addr  <= s_addr_nxt;
            rd_addr <= rd_addr_nxt;
            acc     <= acc_nxt;
            q_reg   <= q_reg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        seq_nxt     = seq_r;
        dim_nxt     = dim_r;
        i_nxt       = i_idx;
        j_nxt       = j_idx;
        k_nxt       = k_idx;
        kb_nxt      = kb_r;
        q_row_nxt   = q_row;
        k_row_nxt   = k_row;
        s_addr_nxt  = s_addr;
        rd_addr_nxt = rd_addr;
        acc_nxt     = acc;
        q_reg_nxt   = q_reg;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    seq_nxt    = seq_len;
                    dim_nxt    = dim;
                    kb_nxt     = k_base;
                    q_row_nxt  = q_base;
                    k_row_nxt  = k_base;
                    s_addr_nxt = s_base;
                    i_nxt      = '0;
                    j_nxt      = '0;
                    k_nxt      = '0;
                    acc_nxt    = '0;
                    if (seq_len == '0 || dim == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = RD_Q;
                        rd_addr_nxt = q_base;
                    end
                end
            end
            RD_Q: begin
                // From k=1 on, the K word requested in the previous RD_K lands now.
                if (k_idx != '0)
                    acc_nxt = acc + prod;
                rd_addr_nxt = k_row + ADDR_WIDTH'(k_idx);
                state_nxt   = RD_K;
            end
            RD_K: begin
                q_reg_nxt = sram_read_data;
                if (k_idx != dim_r - DIM_WIDTH'(1)) begin
                    k_nxt       = k_idx + DIM_WIDTH'(1);
                    rd_addr_nxt = q_row + ADDR_WIDTH'(k_idx + DIM_WIDTH'(1));
                    state_nxt   = RD_Q;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                acc_nxt   = acc + prod;
                state_nxt = WRITE;
            end
            WRITE: begin
                acc_nxt    = '0;
                k_nxt      = '0;
                s_addr_nxt = s_addr + ADDR_WIDTH'(1);
                if (j_idx == seq_r - DIM_WIDTH'(1)) begin
                    j_nxt     = '0;
                    k_row_nxt = kb_r;
                    if (i_idx == seq_r - DIM_WIDTH'(1)) begin
                        state_nxt = IDLE;
                    end else begin
                        i_nxt       = i_idx + DIM_WIDTH'(1);
                        q_row_nxt   = q_row + ADDR_WIDTH'(dim_r);
                        rd_addr_nxt = q_row + ADDR_WIDTH'(dim_r);
                        state_nxt   = RD_Q;
                    end
                end else begin
                    j_nxt       = j_idx + DIM_WIDTH'(1);
                    k_row_nxt   = k_row + ADDR_WIDTH'(dim_r);
                    rd_addr_nxt = q_row;
                    state_nxt   = RD_Q;
                end
            end
            DONE: begin
                // Held for two cycles so an empty launch still shows a 2-cycle busy window.
                if (k_idx == '0) begin
                    k_nxt = DIM_WIDTH'(1);
                end else begin
                    k_nxt     = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ready              = (state == IDLE);
    assign sram_read_address  = rd_addr;
    assign sram_write_enable  = (state == WRITE);
    assign sram_write_address = s_addr;
    assign sram_write_data    = acc;

endmodule

// File: doc/attn_score_engine.md
# attn_score_engine

Computes the attention score matrix S = Q·Kᵀ for one head, where Q and K are the seq_len × dim matrices that the projection stage has already written to the result SRAM. It sits directly downstream of the projection matrix-multiply block. It reads Q and K through the result SRAM read port and writes S back through the result SRAM write port. A start/ready handshake lets the top-level sequencer launch it once projection is complete.

## Interface

Parameters:
- ADDR_WIDTH, 12, SRAM word-address width.
- DATA_WIDTH, 32, SRAM word width; also the element and accumulator width.
- DIM_WIDTH, 16, width of the seq_len and dim operands.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  launch request.
- ready  out  1  high while IDLE; reset value 1.
- seq_len  in  DIM_WIDTH  number of rows in Q and K; sampled at acceptance.
- dim  in  DIM_WIDTH  row length of Q and K; sampled at acceptance.
- q_base  in  ADDR_WIDTH  word address of Q[0][0]; sampled at acceptance.
- k_base  in  ADDR_WIDTH  word address of K[0][0]; sampled at acceptance.
- s_base  in  ADDR_WIDTH  word address of S[0][0]; sampled at acceptance.
- sram_read_address  out  ADDR_WIDTH  result SRAM read address; reset value 0.
- sram_read_data  in  DATA_WIDTH  read data, valid 1 cycle after the address.
- sram_write_enable  out  1  reset value 0.
- sram_write_address  out  ADDR_WIDTH  reset value 0.
- sram_write_data  out  DATA_WIDTH  reset value 0.

## Operation

- **Memory layout.** All matrices are row-major.
  - Q[i][k] is at q_base + i·dim + k.
  - K[j][k] is at k_base + j·dim + k.
  - S[i][j] is at s_base + i·seq_len + j.
  - Address arithmetic wraps mod 2^ADDR_WIDTH.
  - q_base may equal k_base.
- **Acceptance.** start_valid && ready is sampled on an edge (edge E0). At E0 the block latches all operands, ready drops, and the state becomes RD_Q.
  - start_valid while busy is ignored.
- **States.** IDLE, RD_Q, RD_K, DRAIN, WRITE, DONE.
- **Element loop.** Outer index i is 0..seq_len-1; inner index j is 0..seq_len-1; k is the reduction index.
  - RD_Q: drive the Q[i][k] address. If a K word arrived this cycle, accumulate it into acc. Next state is RD_K.
  - RD_K: drive the K[j][k] address and capture sram_read_data (Q[i][k]) into q_reg. Next state is RD_Q if k < dim-1 (k++), otherwise DRAIN.
  - DRAIN: acc += q_reg·sram_read_data (the last K word). Next state is WRITE.
  - WRITE: sram_write_enable = 1, write address is the S[i][j] address, write data = acc. Then clear acc and k, and advance j (and i when j wraps).
    - Next state is RD_Q if elements remain, otherwise IDLE.
  - sram_read_address holds its last value in DRAIN, WRITE and IDLE.
- **Degenerate operands.** If seq_len == 0 or dim == 0, go E0 → DONE → IDLE. No reads or writes occur.
- **Arithmetic.**
  - The product is the low DATA_WIDTH bits of the two's-complement product.
  - Accumulation wraps mod 2^DATA_WIDTH.
  - No saturation and no status flags.
- **Output sourcing.** All outputs are driven from registers or from state decode only; no combinational path from inputs to outputs.
- **Reset.** Assertion mid-operation immediately forces IDLE, ready = 1, write_enable = 0 and all counters/acc = 0. No further writes occur, and already-written elements are not rolled back.

## Timing

- Read latency is one cycle: the address is driven in cycle t and data is sampled at the end of cycle t+1.
- Each element takes 2·dim + 2 cycles.
- With N = seq_len² and E0 the acceptance edge:
  - ready rises at edge E0 + N·(2·dim+2).
  - Write n (0-based) occurs in the cycle ending at edge E0 + (n+1)·(2·dim+2).
- Degenerate case: ready is low for exactly 2 cycles.
- Earliest relaunch: start_valid sampled on the edge where ready is first seen high back-to-back is accepted. The block needs no idle gap.
- write_enable is high for exactly one cycle per element and never twice to the same address within one launch.

## Test plan

- **Basic 2×2.** seq_len=2, dim=2, Q=[[1,2],[3,4]], K=[[5,6],[7,8]] → S=[[17,23],[39,53]] at s_base..s_base+3 in row order. ready returns 24 cycles after E0.
- **Overflow.** seq_len=1, dim=1, Q=[0x7FFFFFFF], K=[2] → S=[0xFFFFFFFE]. Also Q=[-3], K=[4] → S=[0xFFFFFFF4].
- **Self-attention with shared base.** q_base=k_base, seq_len=3, dim=1, data [1,2,3] → S=[1,2,3,2,4,6,3,6,9]. The read-address sequence must match the layout formula exactly.
- **Degenerate.** dim=0, seq_len=4 → zero writes and zero read-address changes; ready low for exactly 2 cycles.
- **Reset mid-run.** Assert reset_n low during the 3rd element of the basic 2×2 case → ready=1 and write_enable=0 at once. Exactly 2 writes occurred. A relaunch then reproduces the full S.
- **Start while busy.** Pulse start_valid with different operands mid-run → ignored, results unchanged. The back-to-back relaunch on the ready edge is accepted.
